// File: rtl/data_mem_stage.sv
// data_mem_stage: parametrised RISC-V MEM stage plus MEM/WB pipeline register.
//
// Holds an XLEN-wide, DEPTH-word data memory with byte-enable stores,
// a synchronous read register, and combinational load extraction
// (B/H/W/D, signed or unsigned) into ReadDataW.
//
// Parameters: XLEN (32 or 64), DEPTH (words, power of two).
// Optional feature macro: DATA_MEM_MISALIGN_TRAP_EN
//   defined   - misaligned load/store is suppressed, MisalignW=1, RegWriteEnW=0
//   undefined - offset is aligned down to the access size, no misalign flag
// A doubleword access with XLEN=32 is always illegal: no access, MisalignW=1.
//
// Ports:
//   clk, rst (async, active-low)
//   RegWriteEnM, MemtoRegM, JALM      -> RegWriteEnW, MemtoRegW, JALW
//   MemReadEnM, MemWriteEnM           load / store request
//   MemSizeM, LoadSizeM, LoadUnsignedM access size (00 B,01 H,10 W,11 D)
//   StallM                            hold W state, suppress store
//   FlushW                            clear W control bits
//   RdM, PcPlus4M, ALUResultM         -> RdW, PcPlus4W, ALUResultW
//   ReadData2M                        store data
//   MisalignW, ReadDataW              fault flag, extended load data
module data_mem_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteEnM,
    input  logic            MemtoRegM,
    input  logic            JALM,
    input  logic            MemReadEnM,
    input  logic            MemWriteEnM,
    input  logic [1:0]      MemSizeM,
    input  logic [1:0]      LoadSizeM,
    input  logic            LoadUnsignedM,
    input  logic            StallM,
    input  logic            FlushW,
    input  logic [4:0]      RdM,
    input  logic [XLEN-1:0] PcPlus4M,
    input  logic [XLEN-1:0] ReadData2M,
    input  logic [XLEN-1:0] ALUResultM,
    output logic            RegWriteEnW,
    output logic            MemtoRegW,
    output logic            JALW,
    output logic            MisalignW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] PcPlus4W,
    output logic [XLEN-1:0] ALUResultW,
    output logic [XLEN-1:0] ReadDataW
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned IDXW = $clog2(DEPTH);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // Low offset bits that must be zero for an access of the given size.
    function automatic logic [OFFW-1:0] size_mask(input logic [1:0] sz);
        logic [3:0] m;
        m = 4'((32'd1 << sz) - 32'd1);
        return m[OFFW-1:0];
    endfunction

    function automatic logic size_illegal(input logic [1:0] sz);
        return (XLEN == 32) && (sz == 2'b11);
    endfunction

    logic [OFFW-1:0] off;
    logic [IDXW-1:0] idx;
    assign off = ALUResultM[OFFW-1:0];
    assign idx = ALUResultM[OFFW +: IDXW];

    logic st_mis, ld_mis, st_bad, ld_bad, acc_fault;
    logic [OFFW-1:0] st_off, ld_off;
    logic mem_we, ld_en;

    assign st_mis = |(off & size_mask(MemSizeM));
    assign ld_mis = |(off & size_mask(LoadSizeM));
    assign st_bad = size_illegal(MemSizeM) | (TRAP_EN & st_mis);
    assign ld_bad = size_illegal(LoadSizeM) | (TRAP_EN & ld_mis);
    // Without trapping, misaligned offsets are forced down to the access size.
    assign st_off = off & ~size_mask(MemSizeM);
    assign ld_off = off & ~size_mask(LoadSizeM);

    assign acc_fault = (MemWriteEnM & st_bad) | (MemReadEnM & ld_bad);
    // rst gates the write so a store on the reset edge is dropped.
    assign mem_we = MemWriteEnM & ~st_bad & ~StallM & rst;
    assign ld_en  = MemReadEnM & ~ld_bad & ~StallM;

    logic regwr_d, misalign_d;
    assign regwr_d    = RegWriteEnM & ~(TRAP_EN & acc_fault);
    assign misalign_d = acc_fault;

    // Byte enables and lane-shifted store data.
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wdata_sh;
    always_comb begin
        int unsigned nbytes;
        nbytes = 32'd1 << MemSizeM;
        be = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            be[b] = (b >= 32'(st_off)) && (b < 32'(st_off) + nbytes);
        end
        wdata_sh = ReadData2M << {st_off, 3'b000};
    end

    // Data memory: not reset, contents persist across rst.
    logic [XLEN-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    logic            regwr_q, mtr_q, jal_q, mis_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_q, alu_q, rdata_q;
    logic [1:0]      lsize_q;
    logic [OFFW-1:0] loff_q;
    logic            luns_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwr_q <= 1'b0;
            mtr_q   <= 1'b0;
            jal_q   <= 1'b0;
            mis_q   <= 1'b0;
            rd_q    <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            lsize_q <= '0;
            loff_q  <= '0;
            luns_q  <= 1'b0;
        end else begin
            // Flush clears control bits even while the stage is stalled.
            if (FlushW) begin
                regwr_q <= 1'b0;
                mtr_q   <= 1'b0;
                jal_q   <= 1'b0;
                mis_q   <= 1'b0;
            end else if (!StallM) begin
                regwr_q <= regwr_d;
                mtr_q   <= MemtoRegM;
                jal_q   <= JALM;
                mis_q   <= misalign_d;
            end
            if (!StallM) begin
                rd_q  <= RdM;
                pc_q  <= PcPlus4M;
                alu_q <= ALUResultM;
            end
            // Read register reads pre-store contents on a combined load/store.
            if (ld_en) begin
                rdata_q <= mem_q[idx];
                lsize_q <= LoadSizeM;
                loff_q  <= ld_off;
                luns_q  <= LoadUnsignedM;
            end
        end
    end

    // Load extraction and extension from the registered read state.
    always_comb begin
        logic [XLEN-1:0] sh, keep, val;
        logic            sbit;
        sh = rdata_q >> {loff_q, 3'b000};
        unique case (lsize_q)
            2'b00: begin keep = XLEN'(8'hFF);         sbit = sh[7];      end
            2'b01: begin keep = XLEN'(16'hFFFF);      sbit = sh[15];     end
            2'b10: begin keep = XLEN'(32'hFFFF_FFFF); sbit = sh[31];     end
            default: begin keep = '1;                 sbit = sh[XLEN-1]; end
        endcase
        val = sh & keep;
        if (!luns_q && sbit) begin
            val = val | ~keep;
        end
        ReadDataW = val;
    end

    assign RegWriteEnW = regwr_q;
    assign MemtoRegW   = mtr_q;
    assign JALW        = jal_q;
    assign MisalignW   = mis_q;
    assign RdW         = rd_q;
    assign PcPlus4W    = pc_q;
    assign ALUResultW  = alu_q;

endmodule

// File: tb/tb_data_mem_stage.sv
module tb_data_mem_stage;

    localparam int unsigned XL   = 64;
    localparam int unsigned DP   = 1024;
    localparam int unsigned MEMB = DP * 8;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM;
    logic [1:0]    MemSizeM, LoadSizeM;
    logic          LoadUnsignedM, StallM, FlushW;
    logic [4:0]    RdM;
    logic [XL-1:0] PcPlus4M, ReadData2M, ALUResultM;
    logic          RegWriteEnW, MemtoRegW, JALW, MisalignW;
    logic [4:0]    RdW;
    logic [XL-1:0] PcPlus4W, ALUResultW, ReadDataW;

    data_mem_stage #(.XLEN(XL), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst),
        .RegWriteEnM(RegWriteEnM), .MemtoRegM(MemtoRegM), .JALM(JALM),
        .MemReadEnM(MemReadEnM), .MemWriteEnM(MemWriteEnM),
        .MemSizeM(MemSizeM), .LoadSizeM(LoadSizeM), .LoadUnsignedM(LoadUnsignedM),
        .StallM(StallM), .FlushW(FlushW), .RdM(RdM),
        .PcPlus4M(PcPlus4M), .ReadData2M(ReadData2M), .ALUResultM(ALUResultM),
        .RegWriteEnW(RegWriteEnW), .MemtoRegW(MemtoRegW), .JALW(JALW),
        .MisalignW(MisalignW), .RdW(RdW), .PcPlus4W(PcPlus4W),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW)
    );

    // Small 32-bit instance for the illegal doubleword case.
    logic        s_rst, s_we, s_re;
    logic [1:0]  s_sz;
    logic [31:0] s_addr, s_wdata;
    logic        s_rw, s_mtr, s_jal, s_mis;
    logic [4:0]  s_rd;
    logic [31:0] s_pc, s_alu, s_rdata;

    data_mem_stage #(.XLEN(32), .DEPTH(16)) dut32 (
        .clk(clk), .rst(s_rst),
        .RegWriteEnM(1'b1), .MemtoRegM(s_re), .JALM(1'b0),
        .MemReadEnM(s_re), .MemWriteEnM(s_we),
        .MemSizeM(s_sz), .LoadSizeM(s_sz), .LoadUnsignedM(1'b0),
        .StallM(1'b0), .FlushW(1'b0), .RdM(5'd3),
        .PcPlus4M(32'h100), .ReadData2M(s_wdata), .ALUResultM(s_addr),
        .RegWriteEnW(s_rw), .MemtoRegW(s_mtr), .JALW(s_jal),
        .MisalignW(s_mis), .RdW(s_rd), .PcPlus4W(s_pc),
        .ALUResultW(s_alu), .ReadDataW(s_rdata)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: byte-addressed memory plus expected W outputs.
    logic [7:0]    mbytes [MEMB];
    logic          e_rw, e_mtr, e_jal, e_mis;
    logic [4:0]    e_rd;
    logic [XL-1:0] e_pc, e_alu, e_rdata;
    bit            rdchk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_rw = 0; e_mtr = 0; e_jal = 0; e_mis = 0;
        e_rd = '0; e_pc = '0; e_alu = '0; e_rdata = '0;
        rdchk = 1'b1;
    endtask

    // Applies the architectural effect of the current inputs at one clock edge.
    task automatic model_edge();
        int unsigned a, nld, nst, ea;
        bit          st_mis, ld_mis, fault;
        logic [63:0] v;
        if (!rst) begin
            model_reset();
            return;
        end
        a      = int'(ALUResultM % 64'(MEMB));
        nld    = 1 << LoadSizeM;
        nst    = 1 << MemSizeM;
        ld_mis = (a % nld) != 0;
        st_mis = (a % nst) != 0;
        fault  = TRAP && ((MemWriteEnM && st_mis) || (MemReadEnM && ld_mis));
        if (!StallM && MemReadEnM && !(TRAP && ld_mis)) begin
            ea = a - (a % nld);
            v  = '0;
            for (int i = 0; i < int'(nld); i++) v = v | (64'(mbytes[ea + i]) << (8 * i));
            if (!LoadUnsignedM && nld < 8 && ((v >> (8 * nld - 1)) & 64'd1) != 0)
                v = v | (~64'd0 << (8 * nld));
            e_rdata = v;
            rdchk   = 1'b1;
        end
        if (!StallM && MemWriteEnM && !(TRAP && st_mis)) begin
            ea = a - (a % nst);
            for (int i = 0; i < int'(nst); i++) mbytes[ea + i] = ReadData2M[8 * i +: 8];
        end
        if (FlushW) begin
            e_rw = 0; e_mtr = 0; e_jal = 0; e_mis = 0;
        end else if (!StallM) begin
            e_rw = RegWriteEnM && !fault; e_mtr = MemtoRegM; e_jal = JALM; e_mis = fault;
        end
        if (!StallM) begin
            e_rd = RdM; e_pc = PcPlus4M; e_alu = ALUResultM;
        end
    endtask

    task automatic check_all();
        check("RegWriteEnW", 64'(RegWriteEnW), 64'(e_rw));
        check("MemtoRegW", 64'(MemtoRegW), 64'(e_mtr));
        check("JALW", 64'(JALW), 64'(e_jal));
        check("MisalignW", 64'(MisalignW), 64'(e_mis));
        check("RdW", 64'(RdW), 64'(e_rd));
        check("PcPlus4W", PcPlus4W, e_pc);
        check("ALUResultW", ALUResultW, e_alu);
        if (rdchk) check("ReadDataW", ReadDataW, e_rdata);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_op(input bit we, input bit re, input logic [1:0] sz, input bit uns,
                          input logic [63:0] addr, input logic [63:0] wd);
        MemWriteEnM = we; MemReadEnM = re; MemSizeM = sz; LoadSizeM = sz;
        LoadUnsignedM = uns; ALUResultM = addr; ReadData2M = wd;
        RegWriteEnM = 1'b1; MemtoRegM = re; JALM = 1'($urandom);
        RdM = 5'($urandom); PcPlus4M = {$urandom, $urandom};
        StallM = 1'b0; FlushW = 1'b0;
    endtask

    typedef struct {
        bit          we;
        bit          re;
        logic [1:0]  sz;
        bit          uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        bit          chk;
        logic [63:0] exp;
        bit          exp_mis;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1, 0, 2'b00, 0, 64'h0,    64'hAA,                 0, 64'h0, 0};
        tbl[1]  = '{0, 1, 2'b00, 0, 64'h0,    64'h0, 1, 64'hFFFFFFFFFFFFFFAA, 0};
        tbl[2]  = '{0, 1, 2'b00, 1, 64'h0,    64'h0, 1, 64'h00000000000000AA, 0};
        tbl[3]  = '{1, 0, 2'b11, 0, 64'h8,    64'h0,                  0, 64'h0, 0};
        tbl[4]  = '{1, 0, 2'b01, 0, 64'h4,    64'hBEEF,               0, 64'h0, 0};
        tbl[5]  = '{1, 0, 2'b10, 0, 64'h8,    64'hDEADBEEF,           0, 64'h0, 0};
        tbl[6]  = '{1, 0, 2'b00, 0, 64'hD,    64'hAB,                 0, 64'h0, 0};
        tbl[7]  = '{0, 1, 2'b01, 0, 64'h4,    64'h0, 1, 64'hFFFFFFFFFFFFBEEF, 0};
        tbl[8]  = '{0, 1, 2'b10, 0, 64'h8,    64'h0, 1, 64'hFFFFFFFFDEADBEEF, 0};
        tbl[9]  = '{0, 1, 2'b10, 1, 64'h8,    64'h0, 1, 64'h00000000DEADBEEF, 0};
        tbl[10] = '{0, 1, 2'b00, 0, 64'hD,    64'h0, 1, 64'hFFFFFFFFFFFFFFAB, 0};
        tbl[11] = '{0, 1, 2'b11, 0, 64'h8,    64'h0, 1, 64'h0000AB00DEADBEEF, 0};
        tbl[12] = '{1, 0, 2'b11, 0, 64'h10,   64'h0123456789ABCDEF,   0, 64'h0, 0};
        tbl[13] = '{0, 1, 2'b11, 0, 64'h10,   64'h0, 1, 64'h0123456789ABCDEF, 0};
        tbl[14] = '{1, 0, 2'b10, 0, 64'h2,    64'h11223344,           0, 64'h0, TRAP};
        tbl[15] = '{0, 1, 2'b00, 1, 64'h0,    64'h0, 1, (TRAP ? 64'hAA : 64'h44), 0};
        tbl[16] = '{0, 1, 2'b11, 0, 64'h2010, 64'h0, 1, 64'h0123456789ABCDEF, 0};
        tbl[17] = '{0, 1, 2'b01, 1, 64'h12,   64'h0, 1, 64'h00000000000089AB, 0};

        rst = 1'b0; s_rst = 1'b0;
        set_op(0, 0, 2'b00, 0, 64'h0, 64'h0);
        s_we = 0; s_re = 0; s_sz = 2'b00; s_addr = '0; s_wdata = '0;
        model_reset();
        #12;
        check_all();
        check("reset_ReadDataW", ReadDataW, 64'h0);
        #5;
        rst = 1'b1; s_rst = 1'b1;

        // Directed table.
        foreach (tbl[i]) begin
            set_op(tbl[i].we, tbl[i].re, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata);
            step();
            if (tbl[i].chk) check($sformatf("tbl%0d_rdata", i), ReadDataW, tbl[i].exp);
            check($sformatf("tbl%0d_mis", i), 64'(MisalignW), 64'(tbl[i].exp_mis));
            check($sformatf("tbl%0d_rw", i), 64'(RegWriteEnW), 64'(!tbl[i].exp_mis));
        end

        // Stall with a store that is then replaced by a load: no write may occur.
        set_op(1, 0, 2'b11, 0, 64'h20, 64'h0); step();
        set_op(1, 0, 2'b11, 0, 64'h28, 64'h0); step();
        set_op(1, 0, 2'b00, 0, 64'h28, 64'h55);
        StallM = 1'b1;
        for (int k = 0; k < 3; k++) step();
        set_op(0, 1, 2'b00, 1, 64'h28, 64'h0); step();
        check("stall_nowrite", ReadDataW, 64'h0);

        // Stall for three cycles, then release the same store: written once.
        set_op(1, 0, 2'b00, 0, 64'h20, 64'h55);
        StallM = 1'b1;
        for (int k = 0; k < 3; k++) step();
        StallM = 1'b0; step();
        set_op(0, 1, 2'b00, 1, 64'h20, 64'h0); step();
        check("stall_release_write", ReadDataW, 64'h55);

        // Flush, and flush during a stall.
        set_op(0, 1, 2'b11, 0, 64'h10, 64'h0); FlushW = 1'b1; step();
        check("flush_rw", 64'(RegWriteEnW), 64'h0);
        set_op(0, 0, 2'b00, 0, 64'h30, 64'h0); FlushW = 1'b1; StallM = 1'b1; step();
        set_op(0, 0, 2'b00, 0, 64'h30, 64'h0); step();

        // Asynchronous reset mid-cycle, then a store across a reset edge.
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        check("midreset_alu", ALUResultW, 64'h0);
        #1 rst = 1'b1;
        set_op(0, 1, 2'b11, 0, 64'h10, 64'h0); step();
        check("mem_after_reset", ReadDataW, 64'h0123456789ABCDEF);
        set_op(1, 0, 2'b00, 0, 64'h28, 64'h77);
        rst = 1'b0;
        step();
        rst = 1'b1;
        set_op(0, 1, 2'b00, 1, 64'h28, 64'h0); step();
        check("store_on_reset_dropped", ReadDataW, 64'h0);

        // XLEN=32 instance: doubleword store is illegal.
        s_we = 1; s_sz = 2'b10; s_addr = 32'h4; s_wdata = 32'hCAFEBABE;
        set_op(0, 0, 2'b00, 0, 64'h40, 64'h0); step();
        check("x32_sw_mis", 64'(s_mis), 64'h0);
        s_sz = 2'b11; s_wdata = 32'h11111111;
        step();
        check("x32_sd_mis", 64'(s_mis), 64'h1);
        s_we = 0; s_re = 1; s_sz = 2'b10;
        step();
        check("x32_lw", 64'(s_rdata), 64'hCAFEBABE);
        check("x32_lw_mis", 64'(s_mis), 64'h0);
        s_re = 0;

        // Randomised phase over a fully initialised 64-byte window.
        for (int w = 0; w < 8; w++) begin
            set_op(1, 0, 2'b11, 0, 64'(w * 8), {$urandom, $urandom});
            step();
        end
        for (int n = 0; n < 400; n++) begin
            set_op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                   64'($urandom_range(0, 63)) + (($urandom % 4 == 0) ? 64'h2000 : 64'h0),
                   {$urandom, $urandom});
            RegWriteEnM = 1'($urandom);
            StallM = ($urandom % 8 == 0);
            FlushW = ($urandom % 8 == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
